// File: rtl/firing_control_pkg.sv
// Shared definitions for the trigger/reload controller and the firing
// datapath: control codes, FSM state encoding and the state->code map.
package firing_control_pkg;

   localparam logic [2:0] CTRL_RELOAD = 3'b000;
   localparam logic [2:0] CTRL_HOLD   = 3'b001;
   localparam logic [2:0] CTRL_SHOT   = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SHOT     = 2'd1,
      ST_COOLDOWN = 2'd2,
      ST_RELOAD   = 2'd3
   } state_t;

   function automatic logic [2:0] ctrl_of(input state_t s);
      unique case (s)
         ST_SHOT:   ctrl_of = CTRL_SHOT;
         ST_RELOAD: ctrl_of = CTRL_RELOAD;
         default:   ctrl_of = CTRL_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button conditioner: 2-FF synchronizer, debounce, rising-edge pulse.
// Ports: clk, reset (sync, active-high), btn (raw async), rise (1-cycle).
module btn_conditioner #(
   parameter int DEBOUNCE_CYC = 250_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [DW-1:0] cnt;
   logic          settle;

   // synced input has disagreed with the level long enough to flip it
   assign settle = (sync2 != level) && (cnt == DB_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         rise  <= settle & sync2;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (settle) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/firing_control.sv
// Trigger/reload FSM driving the datapath control code plus HUD pulses.
// Ports: clk, reset, fire_btn, reload_btn, round_active, remaining_shots
//        -> control, shot_fired, dry_fire, reloading, reload_done.
module firing_control
   import firing_control_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 250_000,
   parameter int COOLDOWN_CYC = 12_500_000,
   parameter int RELOAD_CYC   = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fire_btn,
   input  logic       reload_btn,
   input  logic       round_active,
   input  logic [1:0] remaining_shots,
   output logic [2:0] control,
   output logic       shot_fired,
   output logic       dry_fire,
   output logic       reloading,
   output logic       reload_done
);

   localparam int CMAX = (COOLDOWN_CYC > RELOAD_CYC) ?
                         COOLDOWN_CYC : RELOAD_CYC;
   localparam int CW = $clog2(CMAX);
   localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN_CYC - 1);
   localparam logic [CW-1:0] RL_LAST = CW'(RELOAD_CYC - 1);

   logic          fire_edge;
   logic          reload_edge;
   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic          dry_n;
   logic          done_n;
   logic          fire_ok;
   logic          rel_ok;

   btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_fire (
      .clk   (clk),
      .reset (reset),
      .btn   (fire_btn),
      .rise  (fire_edge)
   );

   btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_reload (
      .clk   (clk),
      .reset (reset),
      .btn   (reload_btn),
      .rise  (reload_edge)
   );

   always_comb begin
      state_n = state;
      cnt_n   = '0;
      dry_n   = 1'b0;
      done_n  = 1'b0;
      fire_ok = fire_edge & (remaining_shots != 2'd0);
      rel_ok  = reload_edge & (remaining_shots != 2'd3);
      unique case (state)
         ST_IDLE: begin
            // fire beats reload unless the magazine is empty
            if (fire_ok)        state_n = ST_SHOT;
            else if (rel_ok)    state_n = ST_RELOAD;
            else if (fire_edge) dry_n   = 1'b1;
         end
         ST_SHOT: state_n = ST_COOLDOWN;
         ST_COOLDOWN: begin
            if (cnt == CD_LAST) state_n = ST_IDLE;
            else                cnt_n   = cnt + CW'(1);
         end
         ST_RELOAD: begin
            if (cnt == RL_LAST) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (!round_active) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
         dry_n   = 1'b0;
         done_n  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         control     <= CTRL_HOLD;
         shot_fired  <= 1'b0;
         dry_fire    <= 1'b0;
         reloading   <= 1'b0;
         reload_done <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         control     <= ctrl_of(state_n);
         shot_fired  <= (state_n == ST_SHOT);
         dry_fire    <= dry_n;
         reloading   <= (state_n == ST_RELOAD);
         reload_done <= done_n;
      end
   end

endmodule

// File: tb/tb_firing_control.sv
// Bench for firing_control: directed vector table plus randomized
// button traffic, both checked against a cycle-level reference model.
module tb_firing_control;

   localparam int DB = 4;
   localparam int CD = 8;
   localparam int RL = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       fire_btn = 1'b0;
   logic       reload_btn = 1'b0;
   logic       round_active = 1'b0;
   logic [1:0] remaining_shots = 2'd3;
   logic [2:0] control;
   logic       shot_fired;
   logic       dry_fire;
   logic       reloading;
   logic       reload_done;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   firing_control #(
      .DEBOUNCE_CYC (DB),
      .COOLDOWN_CYC (CD),
      .RELOAD_CYC   (RL)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .fire_btn        (fire_btn),
      .reload_btn      (reload_btn),
      .round_active    (round_active),
      .remaining_shots (remaining_shots),
      .control         (control),
      .shot_fired      (shot_fired),
      .dry_fire        (dry_fire),
      .reloading       (reloading),
      .reload_done     (reload_done)
   );

   // reference model: raw sample history + mode with a countdown
   typedef enum {M_IDLE, M_SHOT, M_COOL, M_RELOAD} mmode_t;
   mmode_t m_mode = M_IDLE;
   int     m_left = 0;
   bit     fq[$];
   bit     rq[$];
   bit     flev, rlev, frise, rrise;
   bit     m_dry, m_done;

   function automatic bit flips(input bit q[$], input bit lev);
      bit r;
      r = 1'b1;
      // debouncer sees the raw value from two edges ago
      for (int i = 0; i < DB; i++)
         if (q[q.size() - 3 - i] == lev) r = 1'b0;
      return r;
   endfunction

   function automatic logic [6:0] m_exp();
      logic [2:0] c;
      c = (m_mode == M_SHOT) ? 3'b011 :
          (m_mode == M_RELOAD) ? 3'b000 : 3'b001;
      return {c, m_mode == M_SHOT, m_dry,
              m_mode == M_RELOAD, m_done};
   endfunction

   task automatic model_step();
      if (reset) begin
         m_mode = M_IDLE;
         m_left = 0;
         fq.delete();
         rq.delete();
         for (int i = 0; i < DB + 2; i++) begin
            fq.push_back(1'b0);
            rq.push_back(1'b0);
         end
         flev = 0; rlev = 0; frise = 0; rrise = 0;
         m_dry = 0; m_done = 0;
         return;
      end
      fq.push_back(fire_btn);
      rq.push_back(reload_btn);
      void'(fq.pop_front());
      void'(rq.pop_front());
      m_dry = 0;
      m_done = 0;
      if (!round_active) begin
         m_mode = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (frise && remaining_shots != 0) begin
                  m_mode = M_SHOT;
               end else if (rrise && remaining_shots != 3) begin
                  m_mode = M_RELOAD;
                  m_left = RL;
               end else if (frise) begin
                  m_dry = 1;
               end
            end
            M_SHOT: begin
               m_mode = M_COOL;
               m_left = CD;
            end
            M_COOL: begin
               m_left--;
               if (m_left == 0) m_mode = M_IDLE;
            end
            M_RELOAD: begin
               m_left--;
               if (m_left == 0) begin
                  m_mode = M_IDLE;
                  m_done = 1;
               end
            end
            default: m_mode = M_IDLE;
         endcase
      end
      frise = 0;
      rrise = 0;
      if (flips(fq, flev)) begin
         flev = ~flev;
         frise = flev;
      end
      if (flips(rq, rlev)) begin
         rlev = ~rlev;
         rrise = rlev;
      end
   endtask

   function automatic logic [6:0] got();
      return {control, shot_fired, dry_fire, reloading, reload_done};
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      total++;
      if (got() !== m_exp()) begin
         bad++;
         $display("FAIL model t=%0t got=%b exp=%b",
                  $time, got(), m_exp());
      end
   endtask

   typedef struct {
      logic       rst;
      logic       f;
      logic       r;
      logic       ra;
      logic [1:0] sh;
      int         n;
      logic [6:0] e;
   } vec_t;

   vec_t vt[$];

   // e = {control, shot_fired, dry_fire, reloading, reload_done}
   task automatic add(input logic rst, input logic f,
                      input logic r, input logic ra,
                      input logic [1:0] sh, input int n,
                      input logic [6:0] e);
      vec_t v;
      v.rst = rst; v.f = f; v.r = r; v.ra = ra;
      v.sh = sh; v.n = n; v.e = e;
      vt.push_back(v);
   endtask

   initial begin
      // reset, short glitch, first shot and cooldown
      add(1, 0, 0, 0, 3,  3, 7'b001_0000);
      add(0, 1, 0, 1, 3,  2, 7'b001_0000);
      add(0, 0, 0, 1, 3,  6, 7'b001_0000);
      add(0, 1, 0, 1, 3,  7, 7'b011_1000);
      add(0, 1, 0, 1, 3,  1, 7'b001_0000);
      add(0, 1, 0, 1, 3,  7, 7'b001_0000);
      add(0, 1, 0, 1, 3,  4, 7'b001_0000);
      // re-press inside cooldown is dropped
      add(0, 0, 0, 1, 3,  8, 7'b001_0000);
      add(0, 1, 0, 1, 3,  4, 7'b001_0000);
      add(0, 0, 0, 1, 3,  3, 7'b011_1000);
      add(0, 0, 0, 1, 3,  1, 7'b001_0000);
      add(0, 1, 0, 1, 3,  7, 7'b001_0000);
      add(0, 1, 0, 1, 3,  1, 7'b001_0000);
      add(0, 1, 0, 1, 3,  6, 7'b001_0000);
      // press after cooldown
      add(0, 0, 0, 1, 3,  6, 7'b001_0000);
      add(0, 1, 0, 1, 3,  7, 7'b011_1000);
      add(0, 0, 0, 1, 3,  9, 7'b001_0000);
      // dry fire then full reload
      add(0, 1, 0, 1, 0,  7, 7'b001_0100);
      add(0, 1, 0, 1, 0,  1, 7'b001_0000);
      add(0, 0, 1, 1, 0,  7, 7'b000_0010);
      add(0, 0, 1, 1, 0, 15, 7'b000_0010);
      add(0, 0, 1, 1, 0,  1, 7'b001_0001);
      add(0, 0, 0, 1, 0,  1, 7'b001_0000);
      // simultaneous edges and full-magazine reload
      add(1, 0, 0, 1, 1,  1, 7'b001_0000);
      add(0, 1, 1, 1, 1,  7, 7'b011_1000);
      add(0, 0, 0, 1, 1, 12, 7'b001_0000);
      add(1, 0, 0, 1, 0,  1, 7'b001_0000);
      add(0, 1, 1, 1, 0,  7, 7'b000_0010);
      add(0, 0, 0, 1, 0, 16, 7'b001_0001);
      add(1, 0, 0, 1, 3,  1, 7'b001_0000);
      add(0, 0, 1, 1, 3,  9, 7'b001_0000);
      add(0, 0, 0, 1, 3,  6, 7'b001_0000);
      // abort reload by reset, then by round_active
      add(0, 0, 1, 1, 2,  7, 7'b000_0010);
      add(0, 0, 0, 1, 2,  4, 7'b000_0010);
      add(1, 0, 0, 1, 2,  1, 7'b001_0000);
      add(0, 0, 0, 1, 2, 20, 7'b001_0000);
      add(0, 0, 1, 1, 2,  7, 7'b000_0010);
      add(0, 0, 0, 1, 2,  4, 7'b000_0010);
      add(0, 0, 0, 0, 2,  1, 7'b001_0000);
      add(0, 0, 0, 1, 2, 20, 7'b001_0000);
      // trigger while round inactive
      add(0, 1, 0, 0, 2,  8, 7'b001_0000);
      add(0, 0, 0, 1, 2,  8, 7'b001_0000);

      for (int v = 0; v < vt.size(); v++) begin
         reset           = vt[v].rst;
         fire_btn        = vt[v].f;
         reload_btn      = vt[v].r;
         round_active    = vt[v].ra;
         remaining_shots = vt[v].sh;
         for (int c = 0; c < vt[v].n; c++) cycle();
         total++;
         if (got() !== vt[v].e) begin
            bad++;
            $display("FAIL vec%0d got=%b exp=%b",
                     v, got(), vt[v].e);
         end
      end

      round_active = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) fire_btn = ~fire_btn;
         if ($urandom_range(0, 9) == 0) reload_btn = ~reload_btn;
         if ($urandom_range(0, 59) == 0)
            round_active = ~round_active;
         if ($urandom_range(0, 29) == 0)
            remaining_shots = 2'($urandom_range(0, 3));
         reset = ($urandom_range(0, 399) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
